// File: rtl/abc_input_debounce.sv
// Two-flop synchronizer plus debounce for the a/b/c decoder inputs.
// Define ABC_ATOMIC_UPDATE_EN to debounce the 3-bit vector as one unit so all outputs move together.

`ifndef ABC_ATOMIC_UPDATE_EN
module abc_db_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s2_i,
    output logic out_o,
    output logic commit_o
);
    typedef enum logic {ST_STABLE, ST_PENDING} state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        commit  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (s2_i != out_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        out_d  = s2_i;
                        commit = 1'b1;
                    end else begin
                        state_d = ST_PENDING;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                // Any single-cycle return to the held value discards the count.
                if (s2_i == out_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    out_d   = s2_i;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign out_o    = out_q;
    assign commit_o = commit;
endmodule
`endif

module abc_input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       changed
);
    logic [2:0] s1_q, s2_q;
    logic [2:0] out_vec;
    logic       any_commit;
    logic       changed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= sw_in;
            s2_q      <= s1_q;
            changed_q <= any_commit;
        end
    end

`ifdef ABC_ATOMIC_UPDATE_EN
    typedef enum logic {ST_STABLE, ST_PENDING} state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       out_q, out_d;
    logic [2:0]       pend_q, pend_d;
    logic             commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            out_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        pend_d  = pend_q;
        commit  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (s2_q != out_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        out_d  = s2_q;
                        commit = 1'b1;
                    end else begin
                        state_d = ST_PENDING;
                        cnt_d   = CNT_W'(1);
                        pend_d  = s2_q;
                    end
                end
            end
            ST_PENDING: begin
                if (s2_q == out_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (s2_q != pend_q) begin
                    // A different candidate code must prove itself from scratch.
                    cnt_d  = CNT_W'(1);
                    pend_d = s2_q;
                end else if (cnt_q == LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    out_d   = s2_q;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign out_vec    = out_q;
    assign any_commit = commit;
`else
    logic [2:0] lane_commit;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        abc_db_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .s2_i    (s2_q[g]),
            .out_o   (out_vec[g]),
            .commit_o(lane_commit[g])
        );
    end

    assign any_commit = |lane_commit;
`endif

    assign a       = out_vec[2];
    assign b       = out_vec[1];
    assign c       = out_vec[0];
    assign changed = changed_q;
endmodule
